vblank_sequencer: RTL and testbench
===================================

# vblank_sequencer

Frame-synchronous update scheduler for the game core. Watches the pixel coordinates from the VGA timing generator and, once per (divided) frame at the start of vertical blanking, issues a start pulse to each game-update client (bird physics, pipe scroll, collision, score) in fixed index order. It waits for each client's done before starting the next, so state changes happen only while no pixels are drawn. It flags any sequence still running when active video is about to resume.

## Interface
Parameters:
- N_CLIENTS, 4: number of update clients; the sequence order is index 0 to N_CLIENTS-1.
- FRAME_DIV, 1: run one sequence every FRAME_DIV vblank triggers (1..255).
- WDOG_CYCLES, 4096: per-client watchdog limit in clocks (used only with the watchdog macro).

Ports:
- i_clk, in, 1: pixel clock, same clock as the timing generator.
- i_rst, in, 1: reset; synchronous, active-high.
- i_x, in, 10: current h_count from the timing generator.
- i_y, in, 10: current v_count from the timing generator.
- i_pause, in, 1: when high, new triggers are ignored.
- i_done, in, N_CLIENTS: client done pulses, one bit per client.
- i_clr_err, in, 1: clears o_overrun and o_wdog_err.
- o_start, out, N_CLIENTS: one-hot start pulse, one clock wide.
- o_busy, out, 1: high while a sequence is in progress.
- o_seq_done, out, 1: one-clock pulse when a sequence completes normally.
- o_frame_cnt, out, 16: count of sequences started.
- o_overrun, out, 1: sticky; set when the deadline aborts a sequence.
- o_wdog_err, out, N_CLIENTS: sticky; set per client on watchdog timeout.

## Operation
- Trigger: combinational (i_x == 0 && i_y == VA_END+1), where VA_END+1 = 480. It is true for exactly one clock per frame.
- Frame divider: 8-bit counter of triggers seen while not paused. A sequence is accepted when the counter reaches FRAME_DIV-1; the counter then returns to 0.
- Triggers are ignored while o_busy is high or i_pause is high. Pause does not stop a sequence already in progress.
- FSM states:
  - IDLE to START on an accepted trigger. On this transition: idx=0, o_frame_cnt+1 (wraps 0xFFFF to 0).
  - START: o_start[idx]=1 for this clock only. Then go to WAIT.
  - WAIT: sample i_done[idx].
    - If set and idx<N_CLIENTS-1: idx+1, go to START.
    - If set and idx==N_CLIENTS-1: go to FIN.
  - FIN: o_seq_done=1 for one clock. Then go to IDLE.
- i_done bits other than i_done[idx] are ignored, and i_done is ignored outside WAIT.
- A done asserted in the same clock as o_start is not seen, because WAIT begins on the next clock.
- Deadline: in START or WAIT, if i_x == LINE (799) and i_y == SCREEN (524), the FSM aborts to IDLE and sets o_overrun. No o_seq_done is issued and the remaining clients are skipped. Deadline takes priority over a done sampled in the same clock.
- i_clr_err clears o_overrun and o_wdog_err. If a set event occurs in the same clock as i_clr_err, the set wins.
- Reset values: state IDLE, idx 0, divider 0, o_start 0, o_busy 0, o_seq_done 0, o_frame_cnt 0, o_overrun 0, o_wdog_err 0. A reset in mid-sequence drops any o_start pulse in the next clock.

## Timing
- Trigger at clock T gives o_start[0] at T+1 and o_busy high from T+1.
- i_done[i] sampled at clock D gives o_start[i+1] at D+1.
- Last done at D gives o_seq_done at D+1 and o_busy low at D+2.
- Minimum sequence length: 2·N_CLIENTS+1 clocks.
- All outputs are registered. No combinational path from i_done to o_start.

## Configuration
- VBLANK_SEQ_WATCHDOG_EN defined:
  - A 12-bit cycle counter runs in WAIT and resets on each START.
  - When it reaches WDOG_CYCLES-1 without done, o_wdog_err[idx] is set and the FSM advances exactly as if done had been received.
- Undefined: the counter logic is absent, o_wdog_err is tied to 0, and the FSM waits indefinitely, bounded only by the deadline.

## Structure
- Package vga_seq_pkg:
  - Timing constants: HA_END=639, VA_END=479, LINE=799, SCREEN=524.
  - State enum: IDLE, START, WAIT, FIN.
  - CLIENT_IDX_W = $clog2(N_CLIENTS) width helper.
- Sub-module seq_watchdog: a loadable down-counter with expire pulse. It is instantiated only under VBLANK_SEQ_WATCHDOG_EN.

## Test plan
- Each client answers done 3 clocks after its start → o_start sequence 0001, 0010, 0100, 1000 spaced 4 clocks apart; o_seq_done once; o_frame_cnt=1; o_overrun=0.
- FRAME_DIV=3, 6 frames → exactly 2 sequences; o_frame_cnt=2.
- i_pause high across a trigger → no o_start; a sequence already running while pause rises still completes.
- Client 2 never answers, macro undefined → abort at (799,524); o_overrun=1; o_start[3] never pulses; next frame sequences normally; i_clr_err clears o_overrun.
- Macro defined, WDOG_CYCLES=16, client 1 silent → o_wdog_err=0010; o_start[2] 16 clocks after start of WAIT for client 1; o_seq_done issued.
- i_rst pulsed during WAIT for client 1 → all outputs 0 next clock; i_done[1] arriving later is ignored.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// rtl/vga_seq_pkg.sv - shared VGA timing constants, sequencer state type and width helper
package vga_seq_pkg;

  localparam int HA_END = 639;
  localparam int VA_END = 479;
  localparam int LINE   = 799;
  localparam int SCREEN = 524;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  // Client index width; a single client still needs one bit of index.
  function automatic int client_idx_w(input int n_clients);
    return (n_clients > 1) ? $clog2(n_clients) : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - loadable down-counter that flags expiry while running
module seq_watchdog #(
  parameter int             W          = 12,
  parameter logic [W-1:0]   LOAD_VALUE = '1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on each client start, then count down once per waiting clock.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VALUE;
    end else if (i_run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_run && (cnt_q == '0);

endmodule

// File: rtl/vblank_sequencer.sv
// rtl/vblank_sequencer.sv - vblank-triggered client update sequencer; optional watchdog via VBLANK_SEQ_WATCHDOG_EN
module vblank_sequencer
  import vga_seq_pkg::*;
#(
  parameter int N_CLIENTS   = 4,
  parameter int FRAME_DIV   = 1,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [9:0]           i_x,
  input  logic [9:0]           i_y,
  input  logic                 i_pause,
  input  logic [N_CLIENTS-1:0] i_done,
  input  logic                 i_clr_err,
  output logic [N_CLIENTS-1:0] o_start,
  output logic                 o_busy,
  output logic                 o_seq_done,
  output logic [15:0]          o_frame_cnt,
  output logic                 o_overrun,
  output logic [N_CLIENTS-1:0] o_wdog_err
);

  localparam int                   IDX_W    = client_idx_w(N_CLIENTS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_CLIENTS - 1);
  localparam logic [7:0]           DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0 = N_CLIENTS'(1);

  if (FRAME_DIV < 1 || FRAME_DIV > 255 || WDOG_CYCLES < 1 || WDOG_CYCLES > 4096) begin : g_param_check
    $error("vblank_sequencer: FRAME_DIV or WDOG_CYCLES out of range");
  end

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             div_q, div_d;
  logic [15:0]            frame_q, frame_d;
  logic [N_CLIENTS-1:0]   start_q;
  logic                   busy_q;
  logic                   seq_done_q;
  logic                   overrun_q;
  logic                   set_overrun;
  logic                   trig;
  logic                   deadline;
  logic                   wdog_expire;

  // First blanking line starts at x=0 of line VA_END+1; the frame ends at the last pixel clock.
  assign trig     = (i_x == 10'd0) && (i_y == 10'(VA_END + 1));
  assign deadline = (i_x == 10'(LINE)) && (i_y == 10'(SCREEN));

`ifdef VBLANK_SEQ_WATCHDOG_EN
  logic [N_CLIENTS-1:0] wdog_q;
  logic                 wdog_hit;

  seq_watchdog #(
    .W          (12),
    .LOAD_VALUE (12'(WDOG_CYCLES - 1))
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (state_q == START),
    .i_run    (state_q == WAIT),
    .o_expire (wdog_expire)
  );

  // An expiry only counts as an error when it is what moves the sequence on.
  assign wdog_hit = (state_q == WAIT) && !deadline && wdog_expire && !i_done[idx_q];

  // Sticky per-client timeout flags; a new timeout beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= ({N_CLIENTS{wdog_hit}} & (ONE_HOT0 << idx_q)) | (wdog_q & ~{N_CLIENTS{i_clr_err}});
    end
  end

  assign o_wdog_err = wdog_q;
`else
  assign wdog_expire = 1'b0;
  assign o_wdog_err  = '0;
`endif

  // Next-state logic: accept divided triggers when idle, walk clients in order, abort on deadline.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    frame_d     = frame_q;
    set_overrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig && !i_pause) begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            idx_d   = '0;
            frame_d = frame_q + 16'd1;
            state_d = START;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      START: begin
        if (deadline) begin
          state_d     = IDLE;
          set_overrun = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (deadline) begin
          state_d     = IDLE;
          set_overrun = 1'b1;
        end else if (i_done[idx_q] || wdog_expire) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = START;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state so they align with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      div_q      <= '0;
      frame_q    <= '0;
      start_q    <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      frame_q    <= frame_d;
      start_q    <= (state_d == START) ? (ONE_HOT0 << idx_d) : '0;
      busy_q     <= (state_d != IDLE);
      seq_done_q <= (state_d == FIN);
      overrun_q  <= set_overrun | (overrun_q & ~i_clr_err);
    end
  end

  assign o_start     = start_q;
  assign o_busy      = busy_q;
  assign o_seq_done  = seq_done_q;
  assign o_frame_cnt = frame_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_vblank_sequencer.sv
// tb/tb_vblank_sequencer.sv - randomized and directed bench with a timeline model of the sequencer
module tb_vblank_sequencer;

  localparam int N    = 4;
  localparam int FDIV = 3;
  localparam int WDOG = 16;
  localparam int K_FILL = 0;
  localparam int K_TRIG = 1;
  localparam int K_DL   = 2;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [9:0]   i_x, i_y;
  logic         i_pause;
  logic [N-1:0] i_done;
  logic         i_clr_err;
  logic [N-1:0] o_start;
  logic         o_busy;
  logic         o_seq_done;
  logic [15:0]  o_frame_cnt;
  logic         o_overrun;
  logic [N-1:0] o_wdog_err;

  vblank_sequencer #(.N_CLIENTS(N), .FRAME_DIV(FDIV), .WDOG_CYCLES(WDOG)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_pause(i_pause),
    .i_done(i_done), .i_clr_err(i_clr_err), .o_start(o_start), .o_busy(o_busy),
    .o_seq_done(o_seq_done), .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun),
    .o_wdog_err(o_wdog_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: where the sequence is, expressed as the active client and the edge it was started on.
  int           cyc = 0;
  int           m_phase = 0;     // 0 idle, 1 running clients, 2 completion pulse
  int           m_client = 0;
  int           m_start_edge = 0;
  int           m_div = 0;
  int           m_frames = 0;
  bit           m_ov = 0;
  bit [N-1:0]   m_wd = '0;
  logic [N-1:0] exp_start = '0;
  logic         exp_busy = 1'b0;
  logic         exp_sdone = 1'b0;
  logic [15:0]  exp_frame = '0;
  logic         exp_ov = 1'b0;
  logic [N-1:0] exp_wd = '0;

  task automatic model_step();
    bit         trig, dl, adv, set_ov;
    bit [N-1:0] set_wd;
    int         age;
    cyc++;
    if (i_rst) begin
      m_phase = 0; m_div = 0; m_frames = 0; m_ov = 0; m_wd = '0;
      exp_start = '0; exp_busy = 0; exp_sdone = 0; exp_frame = '0; exp_ov = 0; exp_wd = '0;
      return;
    end
    trig = (i_x == 0) && (i_y == 480);
    dl   = (i_x == 799) && (i_y == 524);
    set_ov = 0; set_wd = '0;
    exp_start = '0; exp_sdone = 0;
    if (m_phase == 0) begin
      if (trig && !i_pause) begin
        if (m_div == FDIV - 1) begin
          m_div = 0;
          m_frames = (m_frames + 1) % 65536;
          m_client = 0; m_start_edge = cyc; m_phase = 1;
          exp_start = N'(1);
        end else begin
          m_div++;
        end
      end
    end else if (m_phase == 1) begin
      age = cyc - m_start_edge;
      if (dl) begin
        m_phase = 0; set_ov = 1;
      end else if (age >= 2) begin
        adv = i_done[m_client];
`ifdef VBLANK_SEQ_WATCHDOG_EN
        if (!adv && age == WDOG + 1) begin
          adv = 1; set_wd[m_client] = 1'b1;
        end
`endif
        if (adv) begin
          if (m_client < N - 1) begin
            m_client++; m_start_edge = cyc;
            exp_start = N'(1 << m_client);
          end else begin
            m_phase = 2; exp_sdone = 1;
          end
        end
      end
    end else begin
      m_phase = 0;
    end
    m_ov = set_ov ? 1'b1 : (i_clr_err ? 1'b0 : m_ov);
    m_wd = set_wd | (i_clr_err ? '0 : m_wd);
    exp_busy = (m_phase != 0);
    exp_frame = 16'(m_frames);
    exp_ov = m_ov;
    exp_wd = m_wd;
  endtask

  // Per-cycle comparison of every output against the model.
  bit cmp_en = 0;
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("o_start", 32'(o_start), 32'(exp_start));
      chk("o_busy", 32'(o_busy), 32'(exp_busy));
      chk("o_seq_done", 32'(o_seq_done), 32'(exp_sdone));
      chk("o_frame_cnt", 32'(o_frame_cnt), 32'(exp_frame));
      chk("o_overrun", 32'(o_overrun), 32'(exp_ov));
      chk("o_wdog_err", 32'(o_wdog_err), 32'(exp_wd));
    end
  end

  // Stimulus state: client responders, noise and observation log.
  bit           g_rst = 0, g_pause = 0, g_clr = 0, g_noise = 0, resp_on = 0;
  logic [N-1:0] g_extra = '0;
  bit [N-1:0]   silent = '0;
  int           resp_delay = 3;
  int           resp_cnt [N];
  int           st_cyc[$];
  logic [N-1:0] st_val[$];
  int           n_sdone = 0;

  task automatic clear_log();
    st_cyc.delete(); st_val.delete(); n_sdone = 0;
  endtask

  task automatic tick(input int kind);
    logic [N-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (resp_cnt[k] >= 0) begin
        if (resp_cnt[k] == 0) d[k] = 1'b1;
        resp_cnt[k]--;
      end
    end
    if (g_noise && (cyc % 256) >= 40) d = d | (N'($urandom) & N'($urandom));
    d = d | g_extra;
    case (kind)
      K_TRIG:  begin i_x = 10'd0;   i_y = 10'd480; end
      K_DL:    begin i_x = 10'd799; i_y = 10'd524; end
      default: begin i_x = 10'($urandom_range(1, 798)); i_y = 10'($urandom_range(0, 524)); end
    endcase
    i_rst = g_rst; i_pause = g_pause; i_clr_err = g_clr; i_done = d;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    if (g_rst) for (int k = 0; k < N; k++) resp_cnt[k] = -1;
    if (o_start != '0) begin
      st_cyc.push_back(cyc);
      st_val.push_back(o_start);
      if (resp_on)
        for (int k = 0; k < N; k++)
          if (o_start[k] && !silent[k]) resp_cnt[k] = resp_delay;
    end
    if (o_seq_done) n_sdone++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick(K_FILL);
  endtask

  task automatic wait_start(input logic [N-1:0] val, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick(K_FILL);
      seen = (st_val.size() > 0) && (st_val[st_val.size()-1] == val);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int t_trig, n_keep, n8;
    for (int k = 0; k < N; k++) resp_cnt[k] = -1;
    i_rst = 1; i_x = '0; i_y = '0; i_pause = 0; i_done = '0; i_clr_err = 0;
    @(negedge i_clk);
    cmp_en = 1;
    g_rst = 1; tick_n(2); g_rst = 0;
    chk("rst_start", 32'(o_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_frame", 32'(o_frame_cnt), 32'd0);

    // Clients answer 3 clocks after their start; the third trigger is the accepted one.
    resp_on = 1; resp_delay = 3; silent = '0; clear_log();
    repeat (2) begin tick(K_TRIG); tick_n(10); end
    chk("div_hold_busy", 32'(o_busy), 32'd0);
    tick(K_TRIG); t_trig = cyc; tick_n(30);
    chk("t1_nstart", 32'(st_val.size()), 32'd4);
    if (st_val.size() == 4) begin
      chk("t1_latency", 32'(st_cyc[0]), 32'(t_trig));
      chk("t1_s0", 32'(st_val[0]), 32'b0001);
      chk("t1_s1", 32'(st_val[1]), 32'b0010);
      chk("t1_s2", 32'(st_val[2]), 32'b0100);
      chk("t1_s3", 32'(st_val[3]), 32'b1000);
      for (int i = 1; i < 4; i++) chk($sformatf("t1_gap%0d", i), 32'(st_cyc[i] - st_cyc[i-1]), 32'd4);
    end
    chk("t1_sdone", 32'(n_sdone), 32'd1);
    chk("t1_frame", 32'(o_frame_cnt), 32'd1);
    chk("t1_overrun", 32'(o_overrun), 32'd0);

    // Six triggers with FRAME_DIV=3 give two sequences.
    clear_log();
    repeat (6) begin tick(K_TRIG); tick_n(24); end
    chk("t2_seqs", 32'(n_sdone), 32'd2);
    chk("t2_frame", 32'(o_frame_cnt), 32'd3);

    // Paused triggers are not counted; pause rising mid-sequence does not stop it.
    clear_log(); g_pause = 1;
    repeat (3) begin tick(K_TRIG); tick_n(5); end
    g_pause = 0;
    chk("t3_no_start", 32'(st_val.size()), 32'd0);
    repeat (2) begin tick(K_TRIG); tick_n(5); end
    tick(K_TRIG); tick_n(6); g_pause = 1; tick_n(20); g_pause = 0;
    chk("t3_sdone", 32'(n_sdone), 32'd1);
    chk("t3_frame", 32'(o_frame_cnt), 32'd4);

    // Client 2 silent: deadline aborts, client 3 never starts, next frame runs normally.
    clear_log(); silent = 4'b0100;
    repeat (2) begin tick(K_TRIG); tick_n(5); end
    tick(K_TRIG);
    wait_start(4'b0100, "t4_start2_seen");
    tick_n(5); tick(K_DL); tick_n(5);
    chk("t4_overrun", 32'(o_overrun), 32'd1);
    chk("t4_busy", 32'(o_busy), 32'd0);
    n8 = 0;
    foreach (st_val[i]) if (st_val[i][3]) n8++;
    chk("t4_no_start3", 32'(n8), 32'd0);
    chk("t4_no_sdone", 32'(n_sdone), 32'd0);
    silent = '0; clear_log();
    repeat (3) begin tick(K_TRIG); tick_n(25); end
    chk("t4_recover", 32'(n_sdone), 32'd1);
    g_clr = 1; tick(K_FILL); g_clr = 0;
    chk("t4_clear", 32'(o_overrun), 32'd0);

`ifdef VBLANK_SEQ_WATCHDOG_EN
    // Client 1 silent: watchdog advances 16 clocks into its wait.
    clear_log(); silent = 4'b0010;
    repeat (3) begin tick(K_TRIG); tick_n(3); end
    tick_n(50); silent = '0;
    chk("t5_wdog", 32'(o_wdog_err), 32'b0010);
    chk("t5_nstart", 32'(st_val.size()), 32'd4);
    if (st_val.size() == 4) chk("t5_gap", 32'(st_cyc[2] - st_cyc[1]), 32'd17);
    chk("t5_sdone", 32'(n_sdone), 32'd1);
    g_clr = 1; tick(K_FILL); g_clr = 0;
    chk("t5_clear", 32'(o_wdog_err), 32'd0);
`else
    // Client 1 silent without watchdog: it waits until the deadline.
    clear_log(); silent = 4'b0010;
    repeat (3) begin tick(K_TRIG); tick_n(3); end
    tick_n(40);
    chk("t5_still_busy", 32'(o_busy), 32'd1);
    chk("t5_wdog_tied", 32'(o_wdog_err), 32'd0);
    tick(K_DL); silent = '0;
    chk("t5_abort", 32'(o_busy), 32'd0);
    g_clr = 1; tick(K_FILL); g_clr = 0;
`endif

    // Reset while waiting on client 1; its late done must be ignored.
    clear_log(); silent = 4'b0010;
    repeat (2) begin tick(K_TRIG); tick_n(3); end
    tick(K_TRIG);
    wait_start(4'b0010, "t6_start1_seen");
    tick(K_FILL);
    g_rst = 1; tick(K_FILL); g_rst = 0;
    chk("t6_start", 32'(o_start), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_frame", 32'(o_frame_cnt), 32'd0);
    n_keep = st_val.size();
    tick_n(3); g_extra = 4'b0010; tick(K_FILL); g_extra = '0; tick_n(10);
    chk("t6_ignored", 32'(st_val.size()), 32'(n_keep));
    silent = '0;

    // Random traffic checked cycle by cycle against the model.
    resp_on = 0; g_noise = 1;
    for (int k = 0; k < N; k++) resp_cnt[k] = -1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (i % 64 == 0) g_pause = ($urandom_range(0, 3) == 0);
      g_clr = ($urandom_range(0, 49) == 0);
      g_rst = ($urandom_range(0, 999) == 0);
      r = $urandom_range(0, 99);
      if (i % 30 == 0 || r == 0) tick(K_TRIG);
      else if (r == 1) tick(K_DL);
      else tick(K_FILL);
    end
    g_rst = 0; g_clr = 0; g_pause = 0; g_noise = 0;
    tick_n(2);
    cmp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
